// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI-Lite port arbiter and the bridge it serves.
package axil_arb_pkg;

    // Raw state encodings, kept as plain constants for legacy tooling.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_ADDR = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        WR_REQ  = ST_WR_REQ,
        WR_RESP = ST_WR_RESP,
        RD_ADDR = ST_RD_ADDR,
        RD_DATA = ST_RD_DATA
    } arb_state_t;

    // AXI-Lite response codes shared with the bridge datapath.
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_port_arbiter_if.sv
// Valid/ready handshake pairs of the shared AXI-Lite master port.
interface axil_port_arbiter_if;
    logic awvalid;
    logic awready;
    logic wvalid;
    logic wready;
    logic bvalid;
    logic bready;
    logic arvalid;
    logic arready;
    logic rvalid;
    logic rready;

    modport master (
        output awvalid, wvalid, bready, arvalid, rready,
        input  awready, wready, bvalid, arready, rvalid
    );

    modport slave (
        input  awvalid, wvalid, bready, arvalid, rready,
        output awready, wready, bvalid, arready, rvalid
    );

    // Passive view: the arbiter only watches handshakes, it never drives the bus.
    modport monitor (
        input awvalid, awready, wvalid, wready, bvalid, bready,
              arvalid, arready, rvalid, rready
    );
endinterface

// File: rtl/axil_rr_pick.sv
// Combinational rotating-priority picker: first set req bit after position last.
module axil_rr_pick #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    // One extra bit so last+k never overflows before the modulo fold.
    localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_REQ);

    logic [IDX_W:0] w_pos;

    // Scan from the farthest candidate to the nearest so the nearest match wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_pos = {1'b0, last} + (IDX_W+1)'(k);
            if (w_pos >= N_L) begin
                w_pos = w_pos - N_L;
            end
            if (req[w_pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = w_pos[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/axil_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one AXI-Lite master port among N_REQ requesters.
module axil_port_arbiter
    import axil_arb_pkg::*;
#(
    parameter  int N_REQ          = 2,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int IDX_W          = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            req_we,
    output logic [N_REQ-1:0]            grant,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        grant_we,
    output logic                        busy,
    axil_port_arbiter_if.monitor        m_axil,
    output logic                        timeout,
    output logic [IDX_W-1:0]            timeout_idx
);
    arb_state_t       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_grant_we;
    logic             r_busy;
    logic [IDX_W-1:0] r_last;
    logic             r_aw_done;
    logic             r_w_done;
    logic             r_timeout;
    logic [IDX_W-1:0] r_timeout_idx;

    logic             w_pick_found;
    logic [IDX_W-1:0] w_pick_idx;
    logic [N_REQ-1:0] w_pick_onehot;
    logic             w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic             w_track_hs;
    logic             w_complete;
    logic             w_expire;

    axil_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req),
        .last  (r_last),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
        assign w_pick_onehot[gi] = (w_pick_idx == IDX_W'(gi));
    end

    assign w_aw_hs = m_axil.awvalid & m_axil.awready;
    assign w_w_hs  = m_axil.wvalid  & m_axil.wready;
    assign w_b_hs  = m_axil.bvalid  & m_axil.bready;
    assign w_ar_hs = m_axil.arvalid & m_axil.arready;
    assign w_r_hs  = m_axil.rvalid  & m_axil.rready;

    // Only handshakes on the channel(s) owned by the current state count as progress.
    always_comb begin
        w_track_hs = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            WR_REQ:  w_track_hs = w_aw_hs | w_w_hs;
            WR_RESP: begin w_track_hs = w_b_hs; w_complete = w_b_hs; end
            RD_ADDR: w_track_hs = w_ar_hs;
            RD_DATA: begin w_track_hs = w_r_hs; w_complete = w_r_hs; end
            default: ;
        endcase
    end

    if (TIMEOUT_CYCLES > 0) begin : g_wdog
        localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
        logic [CNT_W-1:0] r_cnt;

        // Stall counter: idle or any tracked progress clears it; it saturates otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (r_state == IDLE || w_track_hs) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        // Any tracked handshake (including a completing one) preempts expiry.
        assign w_expire = (r_state != IDLE) && !w_track_hs &&
                          (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wdog
        assign w_expire = 1'b0;
    end

    // Grant/transaction sequencer; release happens on completion or watchdog expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_we    <= 1'b0;
            r_busy        <= 1'b0;
            r_last        <= IDX_W'(N_REQ - 1);
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_timeout     <= 1'b0;
            r_timeout_idx <= '0;
        end else begin
            r_timeout <= 1'b0;
            if (w_complete || w_expire) begin
                r_state   <= IDLE;
                r_grant   <= '0;
                r_busy    <= 1'b0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                if (w_expire) begin
                    r_timeout     <= 1'b1;
                    r_timeout_idx <= r_grant_idx;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_pick_found) begin
                            r_grant     <= w_pick_onehot;
                            r_grant_idx <= w_pick_idx;
                            r_grant_we  <= req_we[w_pick_idx];
                            r_busy      <= 1'b1;
                            r_last      <= w_pick_idx;
                            r_state     <= req_we[w_pick_idx] ? WR_REQ : RD_ADDR;
                        end
                    end
                    WR_REQ: begin
                        if (w_aw_hs) r_aw_done <= 1'b1;
                        if (w_w_hs)  r_w_done  <= 1'b1;
                        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                            r_state <= WR_RESP;
                        end
                    end
                    RD_ADDR: begin
                        if (w_ar_hs) r_state <= RD_DATA;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_we    = r_grant_we;
    assign busy        = r_busy;
    assign timeout     = r_timeout;
    assign timeout_idx = r_timeout_idx;
endmodule

// File: tb/tb_axil_port_arbiter.sv
// Directed bench for axil_port_arbiter (N_REQ=2, TIMEOUT_CYCLES=16).
module tb_axil_port_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] req_we;
    logic [1:0] grant;
    logic [0:0] grant_idx;
    logic       grant_we;
    logic       busy;
    logic       timeout;
    logic [0:0] timeout_idx;

    int checks = 0;
    int errors = 0;

    axil_port_arbiter_if m_axil();

    axil_port_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_we      (req_we),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_we    (grant_we),
        .busy        (busy),
        .m_axil      (m_axil),
        .timeout     (timeout),
        .timeout_idx (timeout_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive valid and ready together for each channel.
    task automatic set_hs(input logic aw, input logic w, input logic b, input logic ar, input logic r);
        m_axil.awvalid = aw; m_axil.awready = aw;
        m_axil.wvalid  = w;  m_axil.wready  = w;
        m_axil.bvalid  = b;  m_axil.bready  = b;
        m_axil.arvalid = ar; m_axil.arready = ar;
        m_axil.rvalid  = r;  m_axil.rready  = r;
    endtask

    // From a granted write cycle: AW+W together, then B; ends in the IDLE cycle.
    task automatic do_write();
        set_hs(1, 1, 0, 0, 0); tick();
        set_hs(0, 0, 1, 0, 0); tick();
        set_hs(0, 0, 0, 0, 0);
    endtask

    // From a granted read cycle: AR, then R; ends in the IDLE cycle.
    task automatic do_read();
        set_hs(0, 0, 0, 1, 0); tick();
        set_hs(0, 0, 0, 0, 1); tick();
        set_hs(0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [1:0] exp_g [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst_n = 1'b0; req = '0; req_we = '0;
        set_hs(0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_grant",   32'(grant), 32'h0);
        chk("rst_idx",     32'(grant_idx), 32'h0);
        chk("rst_we",      32'(grant_we), 32'h0);
        chk("rst_busy",    32'(busy), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_tidx",    32'(timeout_idx), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single write: AW cycle 3, W cycle 5, B cycle 8.
        $display("txn single write req0");
        req = 2'b01; req_we = 2'b01;                 // cycle 0
        tick();                                      // cycle 1
        chk("w1_grant_c1", 32'(grant), 32'h1);
        chk("w1_we_c1",    32'(grant_we), 32'h1);
        chk("w1_busy_c1",  32'(busy), 32'h1);
        req = 2'b00;
        tick();                                      // cycle 2
        tick(); set_hs(1, 0, 0, 0, 0);               // cycle 3
        tick(); set_hs(0, 0, 0, 0, 0);               // cycle 4
        chk("w1_grant_c4", 32'(grant), 32'h1);
        tick(); set_hs(0, 1, 0, 0, 0);               // cycle 5
        tick(); set_hs(0, 0, 0, 0, 0);               // cycle 6
        chk("w1_grant_c6", 32'(grant), 32'h1);
        tick();                                      // cycle 7
        tick(); set_hs(0, 0, 1, 0, 0);               // cycle 8
        chk("w1_grant_c8", 32'(grant), 32'h1);
        tick(); set_hs(0, 0, 0, 0, 0);               // cycle 9
        chk("w1_grant_c9", 32'(grant), 32'h0);
        chk("w1_busy_c9",  32'(busy), 32'h0);

        // AW and W together; an early B during WR_REQ must be ignored.
        $display("txn write aw+w same cycle req0");
        req = 2'b01; req_we = 2'b01;
        tick();                                      // c1 granted
        req = 2'b00;
        set_hs(0, 0, 1, 0, 0);                       // stray B in WR_REQ
        tick();                                      // c2
        set_hs(1, 1, 0, 0, 0);
        chk("w2_hold_after_b", 32'(grant), 32'h1);
        tick(); set_hs(0, 0, 0, 0, 0);               // c3 WR_RESP
        chk("w2_grant_c3", 32'(grant), 32'h1);
        tick(); set_hs(0, 0, 1, 0, 0);               // c4 B
        chk("w2_grant_c4", 32'(grant), 32'h1);
        tick(); set_hs(0, 0, 0, 0, 0);               // c5
        chk("w2_release", 32'(grant), 32'h0);

        // Stalled read from requester 1: no R ever arrives.
        $display("txn read timeout req1");
        req = 2'b10; req_we = 2'b00;
        tick();                                      // c1 granted
        chk("to_grant", 32'(grant), 32'h2);
        chk("to_idx",   32'(grant_idx), 32'h1);
        chk("to_we",    32'(grant_we), 32'h0);
        req = 2'b00;
        set_hs(0, 0, 0, 1, 0);                       // AR handshake
        tick(); set_hs(0, 0, 0, 0, 0);               // c2, counter at 0
        repeat (15) tick();                          // c17, counter at 15
        chk("to_not_yet", 32'(timeout), 32'h0);
        chk("to_busy_c17", 32'(busy), 32'h1);
        tick();                                      // c18
        chk("to_pulse",  32'(timeout), 32'h1);
        chk("to_tidx",   32'(timeout_idx), 32'h1);
        chk("to_grant0", 32'(grant), 32'h0);
        chk("to_busy0",  32'(busy), 32'h0);
        tick();
        chk("to_pulse_end", 32'(timeout), 32'h0);
        chk("to_tidx_hold", 32'(timeout_idx), 32'h1);

        // req[0] dropped during RD_DATA: grant must hold until R.
        $display("txn read req0 dropped mid-transaction");
        req = 2'b01; req_we = 2'b00;
        tick();                                      // c1
        chk("rd_grant", 32'(grant), 32'h1);
        set_hs(0, 0, 0, 1, 0);
        tick(); set_hs(0, 0, 0, 0, 0);               // c2 RD_DATA
        req = 2'b00;
        tick(); tick();                              // c4
        chk("rd_hold", 32'(grant), 32'h1);
        set_hs(0, 0, 0, 0, 1);
        tick(); set_hs(0, 0, 0, 0, 0);               // c5
        chk("rd_release", 32'(grant), 32'h0);

        // Reset asserted asynchronously while in WR_RESP.
        $display("txn write with reset in WR_RESP");
        req = 2'b01; req_we = 2'b01;
        tick();
        req = 2'b00;
        set_hs(1, 1, 0, 0, 0);
        tick(); set_hs(0, 0, 0, 0, 0);               // WR_RESP
        chk("ar_pre_grant", 32'(grant), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_busy",  32'(busy), 32'h0);
        chk("ar_timeout", 32'(timeout), 32'h0);
        chk("ar_tidx",  32'(timeout_idx), 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Contention after reset: requester 0 first, then strict alternation.
        req = 2'b11; req_we = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("txn contention %0d grant=%b", i, grant);
            chk("rr_grant", 32'(grant), 32'(exp_g[i]));
            chk("rr_idx",   32'(grant_idx), 32'(i % 2));
            chk("rr_we",    32'(grant_we), 32'(i % 2));
            if (i % 2 == 1) do_write();
            else            do_read();
            chk("rr_gap", 32'(grant), 32'h0);
            if (i == 3) req = 2'b00;
        end

        // Only requester 1 asking: it is granted.
        $display("txn read req1 alone");
        req = 2'b10; req_we = 2'b00;
        tick();
        chk("solo1_grant", 32'(grant), 32'h2);
        req = 2'b00;
        do_read();
        chk("solo1_release", 32'(grant), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
